// File: rtl/shift_reg_univ_pkg.sv
// Shared constants for the universal shift register: MODE encodings and
// serialiser FSM state codes.
package shift_reg_univ_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/shift_reg_univ_shift_cell.sv
// One register bit: 4:1 next-value mux (hold / right-shift source /
// left-shift source / parallel bit) feeding a D flop with async clear.
module shift_cell
    import shift_reg_univ_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] sel,
    input  logic       shr_in,
    input  logic       shl_in,
    input  logic       load_in,
    output logic       q
);

    logic q_d;
    logic q_q;

    // Next-value select shared by all cells of the register
    always_comb begin
        q_d = q_q;
        case (sel)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = shr_in;
            MODE_SHL:  q_d = shl_in;
            MODE_LOAD: q_d = load_in;
            default:   q_d = q_q;
        endcase
    end

    // Bit storage with asynchronous clear
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with an LSB-first serialiser:
// START loads I, then WIDTH-1 right shifts follow, then a one-cycle DONE.
module shift_reg_univ
    import shift_reg_univ_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CK,
    input  logic             CL,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             ROT,
    input  logic             SR_IN,
    input  logic             SL_IN,
    input  logic [WIDTH-1:0] I,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             BUSY,
    output logic             DONE
);

    logic [0:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;

    logic [1:0]       sel_s;
    logic             ser_r_s;
    logic             ser_l_s;
    logic [WIDTH-1:0] shr_vec_s;
    logic [WIDTH-1:0] shl_vec_s;
    logic [WIDTH-1:0] reg_q;

    // End-of-register sources: rotate wraps the opposite end, else serial input
    always_comb begin
        ser_r_s   = ROT ? reg_q[0]       : SR_IN;
        ser_l_s   = ROT ? reg_q[WIDTH-1] : SL_IN;
        shr_vec_s = {ser_r_s, reg_q[WIDTH-1:1]};
        shl_vec_s = {reg_q[WIDTH-2:0], ser_l_s};
    end

    // Serialiser FSM: START outranks MODE in IDLE, MODE is ignored in SHIFT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_s   = MODE_HOLD;
        done_d  = 1'b0;
        if (EN) begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        sel_s   = MODE_LOAD;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = ST_SHIFT;
                    end else begin
                        sel_s   = MODE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        sel_s = MODE_SHR;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            sel_s = MODE_HOLD;
        end
        busy_d = (state_d == ST_SHIFT);
    end

    // Control state; DONE naturally drops on the next edge because done_d needs EN
    always_ff @(posedge CK or negedge CL) begin
        if (!CL) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    for (genvar n = 0; n < WIDTH; n++) begin : g_cell
        shift_cell u_cell (
            .clk     (CK),
            .clr_n   (CL),
            .sel     (sel_s),
            .shr_in  (shr_vec_s[n]),
            .shl_in  (shl_vec_s[n]),
            .load_in (I[n]),
            .q       (reg_q[n])
        );
    end

    assign Q    = reg_q;
    assign SO   = reg_q[0];
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ at WIDTH=4: stimulus queues expected
// Q/SO/BUSY/DONE per cycle; a monitor pops and compares them independently.
module tb_shift_reg_univ;
    import shift_reg_univ_pkg::*;

    logic       clk;
    logic       cl, en, rot, sr, sl, start;
    logic [1:0] mode;
    logic [3:0] i_d;
    logic [3:0] q_o;
    logic       so_o, busy_o, done_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    typedef struct {
        int         tgt;
        int         ph;
        logic [3:0] q;
        logic       so;
        logic       busy;
        logic       done;
        string      name;
    } exp_t;

    exp_t sb[$];

    shift_reg_univ #(.WIDTH(4)) dut (
        .CK    (clk),
        .CL    (cl),
        .EN    (en),
        .MODE  (mode),
        .ROT   (rot),
        .SR_IN (sr),
        .SL_IN (sl),
        .I     (i_d),
        .START (start),
        .Q     (q_o),
        .SO    (so_o),
        .BUSY  (busy_o),
        .DONE  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic push(input int tgt, input int ph, input logic [3:0] e_q,
                        input logic e_busy, input logic e_done, input string nm);
        exp_t r;
        r.tgt  = tgt;
        r.ph   = ph;
        r.q    = e_q;
        r.so   = e_q[0];
        r.busy = e_busy;
        r.done = e_done;
        r.name = nm;
        sb.push_back(r);
    endtask

    // Phase 0 is the falling edge, phase 1 is mid-way to the next rising edge
    task automatic check_ph(input int ph);
        exp_t e;
        while (sb.size() > 0 &&
               (sb[0].tgt < cyc_n || (sb[0].tgt == cyc_n && sb[0].ph <= ph))) begin
            e = sb.pop_front();
            n_chk++;
            if (e.tgt < cyc_n) begin
                n_fail++;
                $display("FAIL %s: sample slot missed (cycle %0d, wanted %0d)", e.name, cyc_n, e.tgt);
            end else if (q_o !== e.q || so_o !== e.so || busy_o !== e.busy || done_o !== e.done) begin
                n_fail++;
                $display("FAIL %s: got Q=%b SO=%b BUSY=%b DONE=%b, want Q=%b SO=%b BUSY=%b DONE=%b",
                         e.name, q_o, so_o, busy_o, done_o, e.q, e.so, e.busy, e.done);
            end
        end
    endtask

    always @(negedge clk) begin
        check_ph(0);
        #3;
        check_ph(1);
    end

    task automatic tick(input logic t_en, input logic [1:0] t_mode, input logic t_rot,
                        input logic t_sr, input logic t_sl, input logic [3:0] t_i,
                        input logic t_start, input logic [3:0] e_q,
                        input logic e_busy, input logic e_done, input string nm);
        en    = t_en;
        mode  = t_mode;
        rot   = t_rot;
        sr    = t_sr;
        sl    = t_sl;
        i_d   = t_i;
        start = t_start;
        push(cyc_n + 1, 0, e_q, e_busy, e_done, nm);
        @(posedge clk);
        #1;
    endtask

    // Assert clear between edges and expect the outputs cleared before the next edge
    task automatic do_clear(input string nm);
        @(negedge clk);
        #1;
        cl    = 1'b0;
        start = 1'b0;
        push(cyc_n, 1, 4'b0000, 1'b0, 1'b0, nm);
        @(posedge clk);
        #1;
        cl = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cl = 1'b0; en = 1'b0; rot = 1'b0; sr = 1'b0; sl = 1'b0; start = 1'b0;
        mode = MODE_HOLD; i_d = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        push(cyc_n, 0, 4'b0000, 1'b0, 1'b0, "reset");
        @(posedge clk);
        #1;
        cl = 1'b1;

        // Plain register modes
        tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 4'b1011, 1'b0, 1'b0, "load");
        tick(1'b1, MODE_SHR,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0101, 1'b0, 1'b0, "shr_sin0");
        tick(1'b1, MODE_SHL,  1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b1011, 1'b0, 1'b0, "shl_sin1");
        tick(1'b1, MODE_SHR,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1101, 1'b0, 1'b0, "rot_shr");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1101, 1'b0, 1'b0, "hold");
        tick(1'b1, MODE_SHR,  1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b1110, 1'b0, 1'b0, "shr_sin1");
        tick(1'b1, MODE_SHL,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1101, 1'b0, 1'b0, "rot_shl");
        tick(1'b0, MODE_LOAD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1101, 1'b0, 1'b0, "en_low_freeze");

        // Frame I=0110, MODE=LOAD during the frame must be ignored
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 4'b0110, 1'b1, 1'b0, "f1_start");
        tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0011, 1'b1, 1'b0, "f1_bit1");
        tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, "f1_bit2");
        tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, "f1_bit3");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, "f1_done");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "f1_idle");

        // Same frame stalled two cycles; DONE must clear even with EN low
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 4'b0110, 1'b1, 1'b0, "s_start");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0, "s_bit1");
        tick(1'b0, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0, "s_stall1");
        tick(1'b0, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0, "s_stall2");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "s_bit2");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "s_bit3");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, "s_done");
        tick(1'b0, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "s_done_clr_en0");

        // Collisions: START+LOAD, START while busy, START on the DONE cycle
        tick(1'b1, MODE_LOAD, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b1, 4'b1001, 1'b1, 1'b0, "c_start_vs_load");
        tick(1'b1, MODE_LOAD, 1'b1, 1'b0, 1'b0, 4'b0111, 1'b1, 4'b1100, 1'b1, 1'b0, "c_busy_start1");
        tick(1'b1, MODE_LOAD, 1'b1, 1'b0, 1'b0, 4'b0111, 1'b1, 4'b0110, 1'b1, 1'b0, "c_busy_start2");
        tick(1'b1, MODE_HOLD, 1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, 4'b0011, 1'b1, 1'b0, "c_bit3");
        tick(1'b1, MODE_HOLD, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b1, 4'b0011, 1'b0, 1'b1, "c_start_at_end_ignored");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 4'b0101, 1'b1, 1'b0, "c_start_in_done");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, "c2_bit1");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "c2_bit2");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "c2_bit3");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, "c2_done");

        // Clear with Q=F and BUSY=1
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, "clr_f_start");
        do_clear("clr_f_imm");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "clr_f_nodone1");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "clr_f_nodone2");

        // Clear after two bits, then a clean full frame
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 4'b1011, 1'b1, 1'b0, "m_start");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0101, 1'b1, 1'b0, "m_bit1");
        do_clear("m_clr_imm");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "m_nodone1");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "m_nodone2");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b1, 4'b1100, 1'b1, 1'b0, "m2_start");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0, "m2_bit1");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0, "m2_bit2");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "m2_bit3");
        tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, "m2_done");

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        #4;
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
